branch_predict_unit: RTL and testbench

//  Bimodal branch predictor plus branch/jump resolution for the pipelined CPU.
//  IF stage: looks up a 2-bit-counter BHT and a tagged BTB and returns the next-PC guess.
//  EX stage: resolves the branch/jump, classifies it on the existing `Sequence/`Branch/
//  `NotBranch/`Jump encoding, flags mispredicts, supplies the redirect PC and trains the tables.

---
 rtl/branch_predict_unit_pkg.sv | 15 +
 rtl/bp_sat_counter.sv | 23 ++
 rtl/branch_predict_unit.sv | 121 ++++++++++++
 tb/tb_branch_predict_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the branch predictor: resolved change classes and
// 2-bit counter states.
package branch_predict_unit_pkg;

    localparam logic [1:0] SEQUENCE  = 2'b00;
    localparam logic [1:0] BRANCH    = 2'b01;
    localparam logic [1:0] NOTBRANCH = 2'b10;
    localparam logic [1:0] JUMP      = 2'b11;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter; a jump forces
// the counter straight to strongly-taken.
module bp_sat_counter
    import branch_predict_unit_pkg::*;
(
    input  logic [1:0] cur_i,
    input  logic       taken_i,
    input  logic       jump_i,
    output logic [1:0] nxt_o
);

    always_comb begin
        nxt_o = cur_i;
        if (jump_i) begin
            nxt_o = CTR_ST;
        end else if (taken_i) begin
            if (cur_i != CTR_ST) nxt_o = cur_i + 2'd1;
        end else begin
            if (cur_i != CTR_SNT) nxt_o = cur_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal BHT + tagged BTB lookup for IF, branch/jump resolution, mispredict
// detection and table training for EX.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CNT_W = 32,
    parameter int MODE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              ex_valid,
    input  logic [31:0]       ex_pc,
    input  logic [1:0]        ex_change_type,
    input  logic              ex_reverse,
    input  logic              ex_branch_zero,
    input  logic [31:0]       ex_target,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic [1:0]        branch_or_jump,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [CNT_W-1:0]  perf_branches,
    output logic [CNT_W-1:0]  perf_mispredicts
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = 32 - IDX_W - 2;

    logic             btb_valid_q [ENTRIES];
    logic [TAG_W-1:0] btb_tag_q   [ENTRIES];
    logic [31:0]      btb_tgt_q   [ENTRIES];
    logic [1:0]       ctr_q       [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit;
    logic             ex_taken;
    logic             upd_en, tbl_wr;
    logic [1:0]       ctr_d;
    logic [CNT_W-1:0] perf_branches_q, perf_mispredicts_q;
    logic             unused_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_hit      = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
    assign pred_taken  = (MODE != 0) && if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? btb_tgt_q[if_idx] : if_pc + 32'd4;

    always_comb begin
        ex_taken       = 1'b0;
        branch_or_jump = SEQUENCE;
        if (ex_valid) begin
            case (ex_change_type)
                BRANCH: begin
                    ex_taken       = ex_reverse ^ ex_branch_zero;
                    branch_or_jump = ex_taken ? BRANCH : NOTBRANCH;
                end
                JUMP: begin
                    ex_taken       = 1'b1;
                    branch_or_jump = JUMP;
                end
                default: ;
            endcase
        end
    end

    assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
    assign mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_pred_target != ex_target)));

    assign upd_en = ex_valid && ((ex_change_type == BRANCH) || (ex_change_type == JUMP));
    assign tbl_wr = (MODE != 0) && upd_en;

    bp_sat_counter u_sat (
        .cur_i   (ctr_q[ex_idx]),
        .taken_i (ex_taken),
        .jump_i  (ex_change_type == JUMP),
        .nxt_o   (ctr_d)
    );

    // Taken outcomes overwrite whatever entry aliases this index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
                btb_tag_q[i]   <= '0;
                btb_tgt_q[i]   <= '0;
                ctr_q[i]       <= CTR_WNT;
            end
        end else if (tbl_wr) begin
            ctr_q[ex_idx] <= ctr_d;
            if (ex_taken) begin
                btb_valid_q[ex_idx] <= 1'b1;
                btb_tag_q[ex_idx]   <= ex_tag;
                btb_tgt_q[ex_idx]   <= ex_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            if (upd_en)     perf_branches_q    <= perf_branches_q + CNT_W'(1);
            if (mispredict) perf_mispredicts_q <= perf_mispredicts_q + CNT_W'(1);
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed scenarios plus randomized traffic, checked against a table-level
// model of the predictor.
module tb_branch_predict_unit;

    localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, NBR = 2'b10, JMP = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [1:0]  ex_change_type;
    logic        ex_reverse, ex_branch_zero;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [1:0]  branch_or_jump;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] perf_branches, perf_mispredicts;

    int checks = 0;
    int errors = 0;

    // Reference tables: counter as integer 0..3, BTB as plain arrays.
    int          m_ctr [64];
    bit          m_val [64];
    logic [23:0] m_tag [64];
    logic [31:0] m_tgt [64];
    logic [31:0] m_br, m_mis;

    branch_predict_unit #(.IDX_W(6), .CNT_W(32), .MODE(1)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_change_type(ex_change_type),
        .ex_reverse(ex_reverse), .ex_branch_zero(ex_branch_zero),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .branch_or_jump(branch_or_jump),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_ctr[i] = 1; m_val[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
        end
        m_br = 0; m_mis = 0;
    endtask

    function automatic bit m_pred(input logic [31:0] pc);
        int i = int'(pc[7:2]);
        return m_val[i] && (m_tag[i] == pc[31:8]) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[int'(pc[7:2])] : pc + 32'd4;
    endfunction

    function automatic bit m_taken();
        if (!ex_valid) return 0;
        if (ex_change_type == BR) return ex_reverse ^ ex_branch_zero;
        return ex_change_type == JMP;
    endfunction

    function automatic logic [1:0] m_class();
        if (!ex_valid) return SEQ;
        if (ex_change_type == JMP) return JMP;
        if (ex_change_type == BR) return m_taken() ? BR : NBR;
        return SEQ;
    endfunction

    function automatic bit m_mispredict();
        bit t = m_taken();
        return ex_valid && ((t != ex_pred_taken) || (t && ex_pred_target != ex_target));
    endfunction

    task automatic drive(input logic [31:0] ipc, input logic v, input logic [31:0] pc,
                         input logic [1:0] ty, input logic rev, input logic zero,
                         input logic [31:0] tgt, input logic ept, input logic [31:0] eptgt);
        if_pc = ipc; ex_valid = v; ex_pc = pc; ex_change_type = ty;
        ex_reverse = rev; ex_branch_zero = zero; ex_target = tgt;
        ex_pred_taken = ept; ex_pred_target = eptgt;
        #1;
    endtask

    task automatic check_comb();
        check("pred_taken",     {31'b0, pred_taken}, {31'b0, m_pred(if_pc)});
        check("pred_target",    pred_target, m_pred_tgt(if_pc));
        check("branch_or_jump", {30'b0, branch_or_jump}, {30'b0, m_class()});
        check("mispredict",     {31'b0, mispredict}, {31'b0, m_mispredict()});
        check("redirect_pc",    redirect_pc, m_taken() ? ex_target : ex_pc + 32'd4);
    endtask

    // Clock one edge, apply the same training to the model, re-check counters.
    task automatic tick();
        bit t   = m_taken();
        bit mis = m_mispredict();
        bit upd = ex_valid && (ex_change_type == BR || ex_change_type == JMP);
        int i   = int'(ex_pc[7:2]);
        @(posedge clk);
        if (!rst) begin
            if (upd) begin
                m_br++;
                if (ex_change_type == JMP) m_ctr[i] = 3;
                else if (t)                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                else                       m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                if (t) begin
                    m_val[i] = 1; m_tag[i] = ex_pc[31:8]; m_tgt[i] = ex_target;
                end
            end
            if (mis) m_mis++;
        end
        #1;
        check("perf_branches",    perf_branches, m_br);
        check("perf_mispredicts", perf_mispredicts, m_mis);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        drive(32'h40, 1'b0, 32'h0, SEQ, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        // Reset state
        check("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'h44);
        check("rst_perf", perf_branches | perf_mispredicts, 32'd0);
        check("rst_mispredict", {31'b0, mispredict}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Taken branch at 0x40 resolved twice
        for (int k = 0; k < 2; k++) begin
            drive(32'h40, 1'b1, 32'h40, BR, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44);
            check("t2_mis", {31'b0, mispredict}, 32'd1);
            check("t2_redirect", redirect_pc, 32'h20);
            check("t2_class", {30'b0, branch_or_jump}, {30'b0, BR});
            check_comb();
            tick();
        end
        drive(32'h40, 1'b0, 32'h0, SEQ, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t2_pred", {31'b0, pred_taken}, 32'd1);
        check("t2_pred_tgt", pred_target, 32'h20);

        // Two not-taken resolutions from strongly-taken
        drive(32'h40, 1'b1, 32'h40, BR, 1'b1, 1'b1, 32'h20, 1'b1, 32'h20);
        check("t3_class", {30'b0, branch_or_jump}, {30'b0, NBR});
        check("t3_redirect", redirect_pc, 32'h44);
        check_comb();
        tick();
        drive(32'h40, 1'b1, 32'h40, BR, 1'b1, 1'b1, 32'h20, 1'b1, 32'h20);
        check("t3_still_taken", {31'b0, pred_taken}, 32'd1);
        check_comb();
        tick();
        drive(32'h40, 1'b0, 32'h0, SEQ, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t3_now_nt", {31'b0, pred_taken}, 32'd0);

        // Jump trains to strongly-taken in one shot
        drive(32'h100, 1'b1, 32'h100, JMP, 1'b0, 1'b0, 32'h400, 1'b0, 32'h104);
        check("t4_class", {30'b0, branch_or_jump}, {30'b0, JMP});
        check("t4_mis", {31'b0, mispredict}, 32'd1);
        check_comb();
        tick();
        drive(32'h100, 1'b0, 32'h0, SEQ, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t4_pred", {31'b0, pred_taken}, 32'd1);
        check("t4_pred_tgt", pred_target, 32'h400);

        // Alias at same index with a different tag; wrong predicted target
        drive(32'h40, 1'b1, 32'h40, BR, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44);
        tick();
        drive(32'h140, 1'b1, 32'h80, JMP, 1'b0, 1'b0, 32'h300, 1'b1, 32'h304);
        check("t5_alias", {31'b0, pred_taken}, 32'd0);
        check("t5_mis_tgt", {31'b0, mispredict}, 32'd1);
        check_comb();
        tick();

        // Same-cycle lookup and update of index 16, no bypass
        drive(32'h1040, 1'b1, 32'h1040, JMP, 1'b0, 1'b0, 32'h2000, 1'b0, 32'h1044);
        check("t6_old", {31'b0, pred_taken}, 32'd0);
        check_comb();
        tick();
        drive(32'h1040, 1'b0, 32'h1040, JMP, 1'b0, 1'b0, 32'h3000, 1'b1, 32'h3000);
        check("t6_new", {31'b0, pred_taken}, 32'd1);
        check("t6_new_tgt", pred_target, 32'h2000);
        check("t6_inval_class", {30'b0, branch_or_jump}, {30'b0, SEQ});
        check("t6_inval_mis", {31'b0, mispredict}, 32'd0);
        check_comb();
        tick();

        // Randomized traffic over a few aliasing PCs
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pcs [6];
            logic [31:0] ipc, epc, tgt, ept_t;
            logic        ept;
            pcs[0] = 32'h40; pcs[1] = 32'h140; pcs[2] = 32'h100;
            pcs[3] = 32'h1040; pcs[4] = 32'h7c; pcs[5] = $urandom;
            ipc = pcs[$urandom_range(0, 5)];
            epc = pcs[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
            tgt = {$urandom_range(0, 15), 6'b0};
            if ($urandom_range(0, 1) != 0) begin
                ept = m_pred(epc); ept_t = m_pred_tgt(epc);
            end else begin
                ept = 1'($urandom); ept_t = ($urandom_range(0, 1) != 0) ? tgt : epc + 32'd4;
            end
            drive(ipc, ($urandom_range(0, 7) != 0), epc, 2'($urandom),
                  1'($urandom), 1'($urandom), tgt, ept, ept_t);
            check_comb();
            tick();
        end

        // Reset mid-stream, held across an edge with an eligible jump
        drive(32'h1040, 1'b1, 32'h1040, JMP, 1'b0, 1'b0, 32'h500, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst2_perf_br", perf_branches, 32'd0);
        check("rst2_perf_mis", perf_mispredicts, 32'd0);
        check_comb();
        tick();
        rst = 1'b0;
        drive(32'h1040, 1'b0, 32'h0, SEQ, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rst2_pred", {31'b0, pred_taken}, 32'd0);
        check("rst2_pred_tgt", pred_target, 32'h1044);
        check_comb();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
